i2c_line_filter: RTL and testbench
==================================

// Module: i2c_line_filter
// PURPOSE
//  Front-end conditioning stage for the raw SCL/SDA pad inputs, ahead of the I2C BERT protocol logic.
//  Each line passes through a flop synchronizer and a digital glitch filter.
//  Outputs are clean levels and one-clock edge strobes.
//  Optionally detects I2C START/STOP conditions and tracks bus-busy.
// PARAMETERS
//  SYNC_STAGES    2  synchronizer depth per line; legal 2..4
//  FILTER_CYCLES  3  consecutive stable clocks before a new level is accepted; legal 1..15
// PORTS
//  clk        in   1  system clock, posedge
//  rst_n      in   1  asynchronous reset, active-low
//  scl_i      in   1  raw SCL from pad, asynchronous to clk
//  sda_i      in   1  raw SDA from pad, asynchronous to clk
//  scl_o      out  1  filtered SCL level
//  sda_o      out  1  filtered SDA level
//  scl_rise   out  1  1-clk pulse, scl_o 0->1
//  scl_fall   out  1  1-clk pulse, scl_o 1->0
//  sda_rise   out  1  1-clk pulse, sda_o 0->1
//  sda_fall   out  1  1-clk pulse, sda_o 1->0
//  start_det  out  1  1-clk pulse, START condition
//  stop_det   out  1  1-clk pulse, STOP condition
//  bus_busy   out  1  high between START and STOP
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk release inside block not required):
//    - sync flops=1; scl_o=sda_o=1 (idle bus).
//    - All strobes=0; bus_busy=0; filter counters=0.
//  - Sync: each line is shifted through SYNC_STAGES flops; s = last stage.
//  - Filter, per line, counter cnt of width clog2(FILTER_CYCLES+1):
//    - s==out: cnt<=0.
//    - s!=out and cnt==FILTER_CYCLES-1: out<=s, cnt<=0.
//    - Otherwise: cnt<=cnt+1.
//  - Latency: a clean input step reaches the output SYNC_STAGES+FILTER_CYCLES clocks after the first sampling edge.
//  - Glitches of fewer than FILTER_CYCLES sampled clocks are rejected; a mismatch run that returns to out clears cnt.
//  - Strobes are registered and high for exactly the first clock in which the output shows its new level.
//    - At most one of rise/fall per line per clock.
//  - START: sda_fall while scl_o==1 in the same clock and scl_o was 1 the previous clock.
//  - STOP: sda_rise under the same SCL condition.
//  - SCL and SDA accepted in the same clock (simultaneous edge): neither START nor STOP fires.
//  - bus_busy: set the clock after start_det, cleared the clock after stop_det.
//    - A repeated START while busy keeps bus_busy=1 and still pulses start_det.
//  - Reset mid-operation: all state returns immediately to the reset values.
//    - If a line is low at reset release, its fall strobe fires after SYNC_STAGES+FILTER_CYCLES clocks.
//    - If SDA is low and SCL high at release, start_det also fires; this is the documented behaviour.
// CONFIGURATION
//  Macro I2C_LINE_FILTER_COND_DETECT_EN:
//  - Defined: START/STOP detection and bus_busy as specified above.
//  - Undefined: start_det, stop_det and bus_busy are tied 0, and no detection logic is built.
//  - Levels and edge strobes are unaffected either way.
// STRUCTURE
//  - Shared package/header holds:
//    - I2C_IDLE_LEVEL (1'b1).
//    - Legal-range limits SYNC_STAGES_MIN/MAX and FILTER_CYCLES_MAX.
//    - Parameter range checks go in an elaboration-time assertion.
//  - One sub-module, line_glitch_filter, instantiated twice (SCL, SDA).
//    - Contents: synchronizer, counter, level and rise/fall strobes.
//  - START/STOP and bus_busy logic stays in the top.
// TESTING
//  - Reset: assert rst_n=0 with scl_i=sda_i=0.
//    -> scl_o=sda_o=1, all strobes 0, bus_busy 0 while in reset.
//  - Step: default params, sda_i 1->0 held.
//    -> sda_fall pulses once exactly 5 clocks after the first sampling edge; sda_o=0 thereafter.
//  - Glitch: FILTER_CYCLES=3, scl_i low for 2 clocks, then high.
//    -> scl_o stays 1, no strobes.
//    -> A 3-clock pulse produces scl_fall followed by scl_rise 3 clocks apart.
//  - START/STOP (macro defined): SCL=1, SDA 1->0, then later SDA 0->1.
//    -> start_det 1 clk, bus_busy=1 next clk; stop_det 1 clk, bus_busy=0 next clk.
//  - Simultaneous: scl_i and sda_i fall in the same clock.
//    -> scl_fall and sda_fall in the same clock, no start_det.
//  - Macro undefined: repeat the START/STOP scenario.
//    -> start_det, stop_det and bus_busy remain 0, edge strobes identical.

Source files
------------

// File: rtl/i2c_line_filter_pkg.sv
// rtl/i2c_line_filter_pkg.sv - shared constants, bus-state type and parameter legality check
// for the SCL/SDA line filter.
package i2c_line_filter_pkg;

    localparam logic I2C_IDLE_LEVEL    = 1'b1;

    localparam int   SYNC_STAGES_MIN   = 2;
    localparam int   SYNC_STAGES_MAX   = 4;
    localparam int   FILTER_CYCLES_MIN = 1;
    localparam int   FILTER_CYCLES_MAX = 15;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_e;

    function automatic bit params_legal(input int sync_stages, input int filter_cycles);
        return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
               (filter_cycles >= FILTER_CYCLES_MIN) && (filter_cycles <= FILTER_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/i2c_line_filter_if.sv
// rtl/i2c_line_filter_if.sv - raw pad inputs and conditioned levels/strobes of the line filter.
// master drives the pads and observes results; slave is the filter itself.
interface i2c_line_filter_if;

    logic scl_i;
    logic sda_i;
    logic scl_o;
    logic sda_o;
    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;

    modport master (
        output scl_i,
        output sda_i,
        input  scl_o,
        input  sda_o,
        input  scl_rise,
        input  scl_fall,
        input  sda_rise,
        input  sda_fall,
        input  start_det,
        input  stop_det,
        input  bus_busy
    );

    modport slave (
        input  scl_i,
        input  sda_i,
        output scl_o,
        output sda_o,
        output scl_rise,
        output scl_fall,
        output sda_rise,
        output sda_fall,
        output start_det,
        output stop_det,
        output bus_busy
    );

endinterface

// File: rtl/i2c_line_filter_line_glitch_filter.sv
// rtl/i2c_line_filter_line_glitch_filter.sv - one line: synchronizer, stability counter,
// filtered level and registered rise/fall strobes.
module line_glitch_filter
    import i2c_line_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // A mismatch must persist for FILTER_CYCLES consecutive clocks; any return to the
    // current level restarts the count, so short glitches never reach the output.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], line_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = synced;
            rise_d  = synced;
            fall_d  = ~synced;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
            cnt_q   <= '0;
            level_q <= I2C_IDLE_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - SCL/SDA conditioning front end; START/STOP detection and bus_busy
// are built only when I2C_LINE_FILTER_COND_DETECT_EN is defined.
module i2c_line_filter
    import i2c_line_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_line_filter_if.slave     bus
);

    if (!params_legal(SYNC_STAGES, FILTER_CYCLES)) begin : g_param_check
        $error("i2c_line_filter: SYNC_STAGES or FILTER_CYCLES outside legal range");
    end

    logic scl_level;
    logic scl_rise;
    logic scl_fall;
    logic sda_level;
    logic sda_rise;
    logic sda_fall;

    line_glitch_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_scl_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (bus.scl_i),
        .level_o (scl_level),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    line_glitch_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sda_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (bus.sda_i),
        .level_o (sda_level),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign bus.scl_o    = scl_level;
    assign bus.sda_o    = sda_level;
    assign bus.scl_rise = scl_rise;
    assign bus.scl_fall = scl_fall;
    assign bus.sda_rise = sda_rise;
    assign bus.sda_fall = sda_fall;

`ifdef I2C_LINE_FILTER_COND_DETECT_EN
    logic       scl_prev_q;
    logic       scl_stable_hi;
    logic       start_w;
    logic       stop_w;
    bus_state_e state_q;
    bus_state_e state_d;

    // SCL must have been high the previous clock too, so an SDA edge accepted together
    // with an SCL edge is never mistaken for a bus condition.
    assign scl_stable_hi = scl_level & scl_prev_q;
    assign start_w       = sda_fall & scl_stable_hi;
    assign stop_w        = sda_rise & scl_stable_hi;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BUS_IDLE: if (start_w) state_d = BUS_BUSY;
            BUS_BUSY: if (stop_w)  state_d = BUS_IDLE;
            default:               state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= I2C_IDLE_LEVEL;
            state_q    <= BUS_IDLE;
        end else begin
            scl_prev_q <= scl_level;
            state_q    <= state_d;
        end
    end

    assign bus.start_det = start_w;
    assign bus.stop_det  = stop_w;
    assign bus.bus_busy  = (state_q == BUS_BUSY);
`else
    assign bus.start_det = 1'b0;
    assign bus.stop_det  = 1'b0;
    assign bus.bus_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_line_filter.sv
// tb/tb_i2c_line_filter.sv - directed bench for i2c_line_filter with default parameters.
module tb_i2c_line_filter;

`ifdef I2C_LINE_FILTER_COND_DETECT_EN
    localparam int COND = 1;
`else
    localparam int COND = 0;
`endif

    // Strobe slots: 0 scl_rise, 1 scl_fall, 2 sda_rise, 3 sda_fall, 4 start_det, 5 stop_det
    localparam int S_SCL_RISE = 0;
    localparam int S_SCL_FALL = 1;
    localparam int S_SDA_RISE = 2;
    localparam int S_SDA_FALL = 3;
    localparam int S_START    = 4;
    localparam int S_STOP     = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   both_edges;
    int   cnt   [6];
    int   first [6];
    logic busy_hist [1:16];

    i2c_line_filter_if bus ();

    i2c_line_filter #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.stop_det, bus.start_det, bus.sda_fall, bus.sda_rise, bus.scl_fall, bus.scl_rise};
    endfunction

    // Drive both pads at a negedge, then sample n clocks; index k=1 is the first sampling edge.
    task automatic run(input logic scl, input logic sda, input int n);
        logic [5:0] s;
        bus.scl_i = scl;
        bus.sda_i = sda;
        for (int j = 0; j < 6; j++) begin
            cnt[j]   = 0;
            first[j] = 0;
        end
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            s = strobes();
            for (int j = 0; j < 6; j++) begin
                if (s[j]) begin
                    if (cnt[j] == 0) first[j] = k;
                    cnt[j]++;
                end
            end
            if ((s[0] && s[1]) || (s[2] && s[3])) both_edges++;
            if (k <= 16) busy_hist[k] = bus.bus_busy;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        both_edges = 0;
        rst_n      = 1'b0;
        bus.scl_i  = 1'b0;
        bus.sda_i  = 1'b0;

        // Reset with both pads low: idle-high outputs regardless
        repeat (3) @(negedge clk);
        check("reset_scl_o", bus.scl_o, 1);
        check("reset_sda_o", bus.sda_o, 1);
        check("reset_strobes", strobes(), 0);
        check("reset_busy", bus.bus_busy, 0);

        bus.scl_i = 1'b1;
        bus.sda_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b1, 1'b1, 8);
        check("idle_strobes", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5], 0);

        // SDA falls with SCL high: step latency and START
        run(1'b1, 1'b0, 8);
        check("step_sda_fall_cnt", cnt[S_SDA_FALL], 1);
        check("step_sda_fall_at", first[S_SDA_FALL], 5);
        check("step_sda_o", bus.sda_o, 0);
        check("step_scl_edges", cnt[S_SCL_RISE] + cnt[S_SCL_FALL], 0);
        check("start_cnt", cnt[S_START], COND);
        check("start_at", first[S_START], COND * 5);
        check("busy_before", busy_hist[5], 0);
        check("busy_after_start", busy_hist[6], COND);

        // SDA rises with SCL high: STOP
        run(1'b1, 1'b1, 8);
        check("stop_sda_rise_at", first[S_SDA_RISE], 5);
        check("stop_cnt", cnt[S_STOP], COND);
        check("stop_at", first[S_STOP], COND * 5);
        check("busy_at_stop", busy_hist[5], COND);
        check("busy_after_stop", busy_hist[6], 0);

        // 2-clock SCL glitch is rejected
        run(1'b0, 1'b1, 2);
        check("glitch_strobes_a", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5], 0);
        run(1'b1, 1'b1, 8);
        check("glitch_strobes_b", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5], 0);
        check("glitch_scl_o", bus.scl_o, 1);

        // 3-clock SCL pulse: fall at edge 5, rise at edge 8 (run-2 indices 2 and 5)
        run(1'b0, 1'b1, 3);
        check("pulse_early", cnt[S_SCL_FALL] + cnt[S_SCL_RISE], 0);
        run(1'b1, 1'b1, 10);
        check("pulse_fall_at", first[S_SCL_FALL], 2);
        check("pulse_rise_at", first[S_SCL_RISE], 5);
        check("pulse_fall_cnt", cnt[S_SCL_FALL], 1);
        check("pulse_rise_cnt", cnt[S_SCL_RISE], 1);
        check("pulse_no_cond", cnt[S_START] + cnt[S_STOP], 0);

        // Simultaneous edges on both lines: no START, no STOP
        run(1'b0, 1'b0, 8);
        check("simul_scl_fall_at", first[S_SCL_FALL], 5);
        check("simul_sda_fall_at", first[S_SDA_FALL], 5);
        check("simul_no_start", cnt[S_START], 0);
        run(1'b1, 1'b1, 8);
        check("simul_scl_rise_at", first[S_SCL_RISE], 5);
        check("simul_sda_rise_at", first[S_SDA_RISE], 5);
        check("simul_no_stop", cnt[S_STOP], 0);
        check("simul_busy", bus.bus_busy, 0);

        // Repeated START while busy
        run(1'b1, 1'b0, 8);
        check("rs_first_start", cnt[S_START], COND);
        run(1'b0, 1'b0, 8);
        run(1'b0, 1'b1, 8);
        check("rs_sda_low_scl_no_stop", cnt[S_STOP], 0);
        run(1'b1, 1'b1, 8);
        check("rs_scl_up_no_stop", cnt[S_STOP], 0);
        run(1'b1, 1'b0, 8);
        check("rs_second_start", cnt[S_START], COND);
        check("rs_busy_held_a", busy_hist[1], COND);
        check("rs_busy_held_b", busy_hist[8], COND);
        run(1'b1, 1'b1, 8);
        check("rs_stop", cnt[S_STOP], COND);
        check("rs_busy_end", bus.bus_busy, 0);

        // Asynchronous reset mid-transaction, release with SDA low and SCL high
        run(1'b1, 1'b0, 8);
        check("mid_busy_pre", bus.bus_busy, COND);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sda_o", bus.sda_o, 1);
        check("async_busy", bus.bus_busy, 0);
        check("async_strobes", strobes(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b1, 1'b0, 8);
        check("rel_sda_fall_at", first[S_SDA_FALL], 5);
        check("rel_start", cnt[S_START], COND);
        run(1'b1, 1'b1, 8);
        check("rel_stop", cnt[S_STOP], COND);

        check("one_edge_per_line", both_edges, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
